// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared access-size encodings, controller states and lane masks.
package riscv_mem_pkg;
  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_size_e;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} mem_state_e;
  localparam logic [3:0] LANE_B0  = 4'b0001;
  localparam logic [3:0] LANE_LO  = 4'b0011;
  localparam logic [3:0] LANE_HI  = 4'b1100;
  localparam logic [3:0] LANE_ALL = 4'b1111;
endpackage

// File: rtl/data_mem_controller_if.sv
// data_mem_controller_if: MEM-stage request/response bundle between pipeline and data memory.
interface data_mem_controller_if;
  logic        read;
  logic        write;
  logic [2:0]  funct3;
  logic [31:0] memory_addr;
  logic [31:0] data_to_write;
  logic [31:0] read_data_from_memory_controller;
  logic        mem_ready;
  logic        mem_busy;
  logic        misaligned_fault;
  modport master (
    output read, write, funct3, memory_addr, data_to_write,
    input  read_data_from_memory_controller, mem_ready, mem_busy, misaligned_fault
  );
  modport slave (
    input  read, write, funct3, memory_addr, data_to_write,
    output read_data_from_memory_controller, mem_ready, mem_busy, misaligned_fault
  );
endinterface

// File: rtl/mem_align_unit.sv
// mem_align_unit: byte-lane steering for stores, extraction/extension for loads, alignment faults.
module mem_align_unit
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] raw_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        fault_o
);
  logic        is_b, is_h, is_w;
  logic [31:0] shifted;
  assign is_b    = funct3_i == MEM_B || funct3_i == MEM_BU;
  assign is_h    = funct3_i == MEM_H || funct3_i == MEM_HU;
  assign is_w    = funct3_i == MEM_W;
  assign fault_o = !(is_b || is_h || is_w) || (is_h && addr_lo_i[0]) || (is_w && addr_lo_i != 2'b00);
  assign shifted = raw_i >> {addr_lo_i, 3'b000};
  assign be_o    = is_b ? LANE_B0 << addr_lo_i : is_h ? (addr_lo_i[1] ? LANE_HI : LANE_LO) : LANE_ALL;
  assign wdata_o = is_b ? {4{wdata_i[7:0]}} : is_h ? {2{wdata_i[15:0]}} : wdata_i;
  always_comb
    rdata_o = fault_o ? 32'd0 :
              is_b    ? {{24{funct3_i == MEM_B && shifted[7]}}, shifted[7:0]} :
              is_h    ? {{16{funct3_i == MEM_H && shifted[15]}}, shifted[15:0]} : raw_i;
endmodule

// File: rtl/data_mem_controller.sv
// data_mem_controller: responder for MEM-stage loads/stores on a word SRAM with optional wait states.
module data_mem_controller
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input logic                  clk,
  input logic                  rst,
  data_mem_controller_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = WAIT_STATES > 0 ? 4'(WAIT_STATES - 1) : 4'd0;
  mem_state_e    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW+1:0] addr_q;
  logic [31:0]   data_q, rdata_q, wdata, rdata;
  logic [2:0]    f3_q;
  logic          wr_q, fault_q, fault, req;
  logic [3:0]    be;
  logic [31:0]   mem [DEPTH_WORDS];
  assign req = bus.read | bus.write;
  mem_align_unit u_align (
    .funct3_i (f3_q),
    .addr_lo_i(addr_q[1:0]),
    .wdata_i  (data_q),
    .raw_i    (mem[addr_q[AW+1:2]]),
    .be_o     (be),
    .wdata_o  (wdata),
    .rdata_o  (rdata),
    .fault_o  (fault)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (req) begin
        state_d = WAIT_STATES > 0 ? S_WAIT : S_ACCESS;
        cnt_d   = CNT_INIT;
      end
      S_WAIT: begin
        state_d = cnt_q == 4'd0 ? S_ACCESS : S_WAIT;
        cnt_d   = cnt_q == 4'd0 ? cnt_q : cnt_q - 4'd1;
      end
      S_ACCESS: state_d = S_RESP;
      default:  state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      data_q  <= 32'd0;
      f3_q    <= 3'd0;
      wr_q    <= 1'b0;
      fault_q <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_IDLE && req) begin
        addr_q <= bus.memory_addr[AW+1:0];
        data_q <= bus.data_to_write;
        f3_q   <= bus.funct3;
        wr_q   <= bus.write;
      end
      if (state_q == S_ACCESS) begin
        fault_q <= fault;
        if (!wr_q) rdata_q <= rdata;
      end
    end
  end
  // Reset outranks the store so an aborted access never reaches the array.
  always_ff @(posedge clk)
    if (!rst && state_q == S_ACCESS && wr_q && !fault)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[addr_q[AW+1:2]][8*i +: 8] <= wdata[8*i +: 8];
  assign bus.read_data_from_memory_controller = rdata_q;
  assign bus.mem_ready        = state_q == S_RESP;
  assign bus.misaligned_fault = state_q == S_RESP && fault_q;
  assign bus.mem_busy         = (state_q == S_IDLE && req) || state_q == S_WAIT || state_q == S_ACCESS;
endmodule

// File: tb/tb_data_mem_controller.sv
// tb_data_mem_controller: random and directed loads/stores on a 0- and a 3-wait-state controller vs. a byte-level model.
module tb_data_mem_controller;
  logic        clk = 1'b0, rst = 1'b1;
  logic        sel = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [2:0]  f3 = 3'd0;
  logic [31:0] addr = 32'd0, wd = 32'd0;
  int          errs = 0, checks = 0;
  logic [31:0] model_mem [int];
  logic [31:0] last_rd [2];
  logic [31:0] got;
  data_mem_controller_if bus0 ();
  data_mem_controller_if bus3 ();
  assign bus0.read = rd & ~sel;
  assign bus0.write = wr & ~sel;
  assign bus3.read = rd & sel;
  assign bus3.write = wr & sel;
  assign bus0.funct3 = f3;
  assign bus3.funct3 = f3;
  assign bus0.memory_addr = addr;
  assign bus3.memory_addr = addr;
  assign bus0.data_to_write = wd;
  assign bus3.data_to_write = wd;
  data_mem_controller #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  data_mem_controller #(.DEPTH_WORDS(64), .WAIT_STATES(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));
  wire        ready = sel ? bus3.mem_ready : bus0.mem_ready;
  wire        busy  = sel ? bus3.mem_busy : bus0.mem_busy;
  wire        flt   = sel ? bus3.misaligned_fault : bus0.misaligned_fault;
  wire [31:0] rdq   = sel ? bus3.read_data_from_memory_controller : bus0.read_data_from_memory_controller;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit s, input bit w, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] erd, output logic ef);
    int key, lo, sz;
    logic [31:0] word, v;
    key = (s ? 4096 : 0) + int'((a >> 2) % (s ? 64 : 1024));
    word = model_mem.exists(key) ? model_mem[key] : 32'd0;
    lo = int'(a % 4);
    sz = (f == 3'd0 || f == 3'd4) ? 1 : (f == 3'd1 || f == 3'd5) ? 2 : (f == 3'd2) ? 4 : 0;
    ef = sz == 0 || (lo % sz) != 0;
    erd = last_rd[s];
    if (w) begin
      if (!ef) begin
        for (int i = 0; i < sz; i++) word[8*(lo+i) +: 8] = d[8*i +: 8];
        model_mem[key] = word;
      end
    end else begin
      v = word >> (8 * lo);
      if (sz == 1) v = v & 32'hFF;
      if (sz == 2) v = v & 32'hFFFF;
      if (f == 3'd0 && v >= 32'd128) v = v - 32'd256;
      if (f == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
      erd = ef ? 32'd0 : v;
      last_rd[s] = erd;
    end
  endtask

  task automatic do_op(input bit s, input bit r, input bit w, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] d, input bit chg, output logic [31:0] res);
    logic [31:0] erd;
    logic        ef, done;
    int          n, bn, lat;
    model(s, w, f, a, d, erd, ef);
    lat = s ? 5 : 2;
    @(negedge clk);
    sel = s; rd = r; wr = w; f3 = f; addr = a; wd = d;
    #1;
    n = 0; bn = busy ? 1 : 0; done = 1'b0;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
      if (ready) done = 1'b1;
      else begin
        bn += busy ? 1 : 0;
        if (chg && n == 2) addr = a ^ 32'h4;
      end
    end
    check("timeout", {31'd0, done}, 32'd1);
    check("latency", n, lat);
    check("busy_cycles", bn, lat);
    check("busy_in_resp", {31'd0, busy}, 32'd0);
    check("fault", {31'd0, flt}, {31'd0, ef});
    check("rdata", rdq, erd);
    res = rdq;
    rd = 1'b0; wr = 1'b0;
    @(negedge clk);
    check("ready_pulse", {31'd0, ready}, 32'd0);
  endtask

  initial begin
    logic [2:0]  rf;
    logic [31:0] ra;
    bit          rw;
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_ready0", {31'd0, bus0.mem_ready}, 32'd0);
    check("rst_busy0", {31'd0, bus0.mem_busy}, 32'd0);
    check("rst_rdata0", bus0.read_data_from_memory_controller, 32'd0);
    check("rst_fault0", {31'd0, bus0.misaligned_fault}, 32'd0);
    check("rst_ready3", {31'd0, bus3.mem_ready}, 32'd0);
    check("rst_rdata3", bus3.read_data_from_memory_controller, 32'd0);
    do_op(0, 0, 1, 3'd2, 32'h10, 32'hDEADBEEF, 0, got);
    do_op(0, 1, 0, 3'd2, 32'h10, 32'h0, 0, got);       check("lw_10", got, 32'hDEADBEEF);
    do_op(0, 0, 1, 3'd2, 32'h20, 32'h80FF7F01, 0, got);
    do_op(0, 1, 0, 3'd0, 32'h23, 32'h0, 0, got);       check("lb_23", got, 32'hFFFFFF80);
    do_op(0, 1, 0, 3'd4, 32'h23, 32'h0, 0, got);       check("lbu_23", got, 32'h00000080);
    do_op(0, 1, 0, 3'd1, 32'h22, 32'h0, 0, got);       check("lh_22", got, 32'hFFFF80FF);
    do_op(0, 1, 0, 3'd5, 32'h20, 32'h0, 0, got);       check("lhu_20", got, 32'h00007F01);
    do_op(0, 1, 0, 3'd0, 32'h21, 32'h0, 0, got);       check("lb_21", got, 32'h0000007F);
    do_op(0, 0, 1, 3'd2, 32'h30, 32'h11223344, 0, got);
    do_op(0, 0, 1, 3'd0, 32'h31, 32'h000000AB, 0, got);
    do_op(0, 1, 0, 3'd2, 32'h30, 32'h0, 0, got);       check("sb_merge", got, 32'h1122AB44);
    do_op(0, 0, 1, 3'd1, 32'h32, 32'h0000CAFE, 0, got);
    do_op(0, 1, 0, 3'd2, 32'h30, 32'h0, 0, got);       check("sh_merge", got, 32'hCAFEAB44);
    do_op(0, 0, 1, 3'd2, 32'h14, 32'h55AA55AA, 0, got);
    do_op(0, 1, 0, 3'd2, 32'h13, 32'h0, 0, got);       check("lw_mis_data", got, 32'h0);
    do_op(0, 0, 1, 3'd1, 32'h15, 32'h00001234, 0, got);
    do_op(0, 1, 0, 3'd2, 32'h14, 32'h0, 0, got);       check("sh_mis_nowrite", got, 32'h55AA55AA);
    do_op(0, 1, 0, 3'd3, 32'h10, 32'h0, 0, got);       check("f3_011_data", got, 32'h0);
    do_op(0, 0, 1, 3'd2, 32'h40, 32'h0BADF00D, 0, got);
    @(negedge clk);
    sel = 0; wr = 1; f3 = 3'd2; addr = 32'h40; wd = 32'h12345678;
    @(negedge clk);
    rst = 1'b1; wr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", {31'd0, ready}, 32'd0);
    check("abort_rdata", rdq, 32'd0);
    check("abort_fault", {31'd0, flt}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_ready", {31'd0, ready}, 32'd0);
    end
    do_op(0, 1, 0, 3'd2, 32'h40, 32'h0, 0, got);       check("abort_nowrite", got, 32'h0BADF00D);
    do_op(0, 1, 1, 3'd2, 32'h44, 32'h5, 0, got);
    do_op(0, 1, 0, 3'd2, 32'h44, 32'h0, 0, got);       check("write_wins", got, 32'h5);
    do_op(1, 0, 1, 3'd2, 32'h50, 32'hA5A5A5A5, 0, got);
    do_op(1, 0, 1, 3'd2, 32'h54, 32'h5A5A5A5A, 0, got);
    do_op(1, 1, 0, 3'd2, 32'h50, 32'h0, 1, got);       check("wait_captured_addr", got, 32'hA5A5A5A5);
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 16; i++)
        do_op(s[0], 0, 1, 3'd2, 32'h100 + 32'(4 * i), $urandom, 0, got);
      for (int i = 0; i < 60; i++) begin
        rw = $urandom_range(0, 2) == 0;
        rf = 3'($urandom_range(0, 7));
        if (rw && (rf == 3'd4 || rf == 3'd5)) rf = rf - 3'd4;
        ra = 32'h100 + 32'($urandom_range(0, 63)) + (32'($urandom_range(0, 7)) << (s == 1 ? 8 : 12));
        do_op(s[0], !rw || $urandom_range(0, 3) == 0, rw, rf, ra, $urandom, 0, got);
      end
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/data_mem_controller.md
Name: data_mem_controller

Overview:
- Responder end of the MEM-stage data-memory interface.
- Accepts level-held read/write requests (read, write, memory_addr, data_to_write) plus access size.
- Performs aligned byte/half/word accesses on an internal word-organised SRAM, with configurable wait states.
- Returns aligned, sign/zero-extended load data on read_data_from_memory_controller, and drives a busy/ready handshake that stalls the pipeline.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array; power of two.
- WAIT_STATES, 0, extra cycles inserted between request capture and array access (0..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- read  in  1  load request; level, held by requester until mem_ready.
- write  in  1  store request; level, held by requester until mem_ready.
- funct3  in  3  RISC-V load/store funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- memory_addr  in  32  byte address.
- data_to_write  in  32  store data; low bits used for B/H.
- read_data_from_memory_controller  out  32  extended load data; valid while mem_ready=1 for a read.
- mem_ready  out  1  one-cycle completion pulse.
- mem_busy  out  1  stall request to pipeline.
- misaligned_fault  out  1  valid with mem_ready; access rejected.

Behaviour:
- Reset (rst=1 at clk edge): state IDLE, wait counter 0, read_data_from_memory_controller=0, mem_ready=0, misaligned_fault=0. Array contents are not reset.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - If read|write: capture addr, data, funct3, and op.
  - Go to WAIT if WAIT_STATES>0 (counter loaded with WAIT_STATES-1), else to ACCESS.
  - read=write=1 together: write wins.
- WAIT: counter decrements; when 0, go to ACCESS.
- ACCESS:
  - Fault check: fault if funct3 is 011, 110 or 111; if half and addr[0]=1; or if word and addr[1:0]≠0.
  - No fault, write: array[word_idx] updated under byte mask.
    - B: mask 1<<addr[1:0], byte replicated to all lanes.
    - H: mask 0011 or 1100 by addr[1].
    - W: 1111.
  - No fault, read: word registered, then extracted at addr[1:0] and sign- or zero-extended per funct3.
  - Fault: no array write, read data forced to 0.
  - Go to RESP.
- RESP: mem_ready=1 for exactly one cycle; misaligned_fault valid; go to IDLE.
- read_data_from_memory_controller holds its last value until the next read RESP. It is 0 after a faulted read; writes do not alter it.
- mem_busy (combinational) = (IDLE & (read|write)) | WAIT | ACCESS. It is 0 in RESP, so the pipeline advances on the mem_ready cycle.
- Latency: request-to-mem_ready = 2 + WAIT_STATES cycles.
- Back-to-back: a request still asserted in the cycle after RESP is captured as a new access. The requester must deassert or change the request after mem_ready.
- Address range: word_idx = memory_addr[$clog2(DEPTH_WORDS)+1:2]; upper bits are ignored (aliasing, no fault).
- Request changes mid-access: ignored; captured values are used.
- Reset mid-operation:
  - Any state returns to IDLE.
  - Reset asserted in the ACCESS cycle suppresses the array write (reset has priority).
  - No mem_ready is emitted for an aborted access.

Decomposition:
- Package riscv_mem_pkg holds:
  - mem_size_e enum (funct3 encodings).
  - mem_state_e enum (IDLE/WAIT/ACCESS/RESP).
  - Lane-mask constants.
- Sub-module mem_align_unit (combinational) provides:
  - Store side: byte mask and lane-replicated write data from funct3/addr[1:0].
  - Load side: extraction/extension from the raw word.
  - Fault detection.
- Controller holds the FSM, capture registers, counter and array.

Test Plan:
- WAIT_STATES=0: sw 0xDEADBEEF @0x10, then lw @0x10 → mem_ready 2 cycles after each request; mem_busy high 2 cycles; read data 0xDEADBEEF; fault 0.
- After word 0x80FF7F01 @0x20: lb @0x23 → 0xFFFFFF80; lbu @0x23 → 0x00000080; lh @0x22 → 0xFFFF80FF; lhu @0x20 → 0x00007F01; lb @0x21 → 0x0000007F.
- sb 0xAB @0x31 over word 0x11223344 → lw @0x30 returns 0x1122AB44. sh 0xCAFE @0x32 → 0xCAFEAB44.
- lw @0x13 and sh @0x15 → mem_ready with misaligned_fault=1, read data 0, target word unchanged. funct3=011 → fault.
- WAIT_STATES=3: lw → mem_ready exactly 5 cycles after request; mem_busy high 5 cycles; memory_addr changed during WAIT still reads the captured address.
- sw 0x12345678 @0x40 with rst pulsed in the ACCESS cycle → no mem_ready, outputs 0; subsequent lw @0x40 returns the prior contents. Also read=write=1 @0x44 with data 0x5 → write performed.
